// File: rtl/param_deserialiser.sv
// Bit-to-word deserialiser for the ISO/IEC 14443-3A receive path.
// Define PARAM_DESERIALISER_PARITY_CHECK_EN to expect an odd-parity bit after every word.
module param_deserialiser #(
    parameter int WORD_BITS = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WORD_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_soc,
    input  logic                 in_eoc,
    input  logic                 in_error,
    input  logic                 in_data_valid,
    input  logic                 in_data,
    output logic                 out_soc,
    output logic                 out_eoc,
    output logic                 out_error,
    output logic                 out_data_valid,
    output logic [WORD_BITS-1:0] out_data,
    output logic [CNT_W-1:0]     out_data_bits
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
`ifdef PARAM_DESERIALISER_PARITY_CHECK_EN
        PARITY = 2'd2,
`endif
        ERROR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

`ifdef PARAM_DESERIALISER_PARITY_CHECK_EN
    function automatic logic parity_ok(input logic [WORD_BITS-1:0] w, input logic p);
        return (^w) ^ p;
    endfunction
`endif

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt_p0, cnt_nxt;
    logic [WORD_BITS-1:0] shreg_p0, shreg_nxt;
    logic [WORD_BITS-1:0] word;
    logic [CNT_W-1:0]     pos;
    logic                 full;
    logic                 soc_nxt, eoc_nxt, err_nxt, dv_nxt;
    logic [WORD_BITS-1:0] data_nxt;
    logic [CNT_W-1:0]     bits_nxt;

    always_comb begin
        pos  = LSB_FIRST ? cnt_p0 : (LAST - cnt_p0);
        word = shreg_p0;
        full = 1'b0;
        if (in_data_valid) begin
            word[pos] = in_data;
            full      = (cnt_p0 == LAST);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_p0;
        shreg_nxt = shreg_p0;
        soc_nxt   = 1'b0;
        eoc_nxt   = 1'b0;
        err_nxt   = 1'b0;
        dv_nxt    = 1'b0;
        data_nxt  = '0;
        bits_nxt  = '0;
        if (in_soc) begin
            soc_nxt   = 1'b1;
            cnt_nxt   = '0;
            shreg_nxt = '0;
            state_nxt = DATA;
        end else begin
            case (state)
                IDLE: ;
                DATA: begin
                    if (in_error) begin
                        err_nxt   = 1'b1;
                        eoc_nxt   = in_eoc;
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                        state_nxt = in_eoc ? IDLE : ERROR;
                    end else begin
                        if (in_data_valid) begin
                            if (full) begin
                                cnt_nxt = '0;
`ifdef PARAM_DESERIALISER_PARITY_CHECK_EN
                                shreg_nxt = word;
                                state_nxt = PARITY;
`else
                                shreg_nxt = '0;
                                dv_nxt    = 1'b1;
                                data_nxt  = word;
`endif
                            end else begin
                                cnt_nxt   = cnt_p0 + ONE;
                                shreg_nxt = word;
                            end
                        end
                        // The accepted bit is folded in before the end of frame is reported
                        if (in_eoc) begin
                            eoc_nxt   = 1'b1;
                            cnt_nxt   = '0;
                            shreg_nxt = '0;
                            state_nxt = IDLE;
`ifdef PARAM_DESERIALISER_PARITY_CHECK_EN
                            if (full) begin
                                err_nxt = 1'b1;
                            end else begin
                                data_nxt = word;
                                bits_nxt = in_data_valid ? cnt_p0 + ONE : cnt_p0;
                            end
`else
                            if (!full) begin
                                data_nxt = word;
                                bits_nxt = in_data_valid ? cnt_p0 + ONE : cnt_p0;
                            end
`endif
                        end
                    end
                end
`ifdef PARAM_DESERIALISER_PARITY_CHECK_EN
                PARITY: begin
                    if (in_error || in_eoc) begin
                        err_nxt   = 1'b1;
                        eoc_nxt   = in_eoc;
                        shreg_nxt = '0;
                        state_nxt = in_eoc ? IDLE : ERROR;
                    end else if (in_data_valid) begin
                        shreg_nxt = '0;
                        if (parity_ok(shreg_p0, in_data)) begin
                            dv_nxt    = 1'b1;
                            data_nxt  = shreg_p0;
                            state_nxt = DATA;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ERROR;
                        end
                    end
                end
`endif
                ERROR: begin
                    if (in_eoc) begin
                        eoc_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Registered outputs: one cycle after the triggering input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt_p0         <= '0;
            shreg_p0       <= '0;
            out_soc        <= 1'b0;
            out_eoc        <= 1'b0;
            out_error      <= 1'b0;
            out_data_valid <= 1'b0;
            out_data       <= '0;
            out_data_bits  <= '0;
        end else begin
            state          <= state_nxt;
            cnt_p0         <= cnt_nxt;
            shreg_p0       <= shreg_nxt;
            out_soc        <= soc_nxt;
            out_eoc        <= eoc_nxt;
            out_error      <= err_nxt;
            out_data_valid <= dv_nxt;
            out_data       <= data_nxt;
            out_data_bits  <= bits_nxt;
        end
    end

endmodule

// File: tb/tb_param_deserialiser.sv
// Bench for param_deserialiser: an 8-bit LSB-first and a 16-bit MSB-first instance share
// one directed stimulus stream and are checked against a bit-list frame model every cycle.
module tb_param_deserialiser;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_soc = 1'b0, in_eoc = 1'b0, in_error = 1'b0, in_data_valid = 1'b0, in_data = 1'b0;

    logic       o8_soc, o8_eoc, o8_err, o8_dv;
    logic [7:0] o8_data;
    logic [2:0] o8_bits;
    logic        o16_soc, o16_eoc, o16_err, o16_dv;
    logic [15:0] o16_data;
    logic [3:0]  o16_bits;

    param_deserialiser #(.WORD_BITS(8), .LSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .out_soc(o8_soc), .out_eoc(o8_eoc), .out_error(o8_err), .out_data_valid(o8_dv),
        .out_data(o8_data), .out_data_bits(o8_bits)
    );

    param_deserialiser #(.WORD_BITS(16), .LSB_FIRST(1'b0)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .out_soc(o16_soc), .out_eoc(o16_eoc), .out_error(o16_err), .out_data_valid(o16_dv),
        .out_data(o16_data), .out_data_bits(o16_bits)
    );

    always #5 clk = ~clk;

`ifdef PARAM_DESERIALISER_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    bit run = 1'b0;

    // Frame model: per instance, the list of bits received in the current word
    int  W[2]   = '{8, 16};
    bit  LSB[2] = '{1'b1, 1'b0};
    bit  m_active[2], m_errd[2], m_pw[2];
    int  m_n[2];
    bit  m_b[2][32];
    logic        e_soc[2], e_eoc[2], e_err[2], e_dv[2];
    logic [31:0] e_data[2];
    int          e_bits[2];
    int c_soc[2], c_eoc[2], c_err[2], c_dv[2];

    function automatic logic [31:0] pack(int d, int cnt);
        logic [31:0] r = '0;
        for (int i = 0; i < cnt; i++)
            if (m_b[d][i]) r[LSB[d] ? i : W[d] - 1 - i] = 1'b1;
        return r;
    endfunction

    task automatic model_step(int d);
        int ones;
        e_soc[d] = 0; e_eoc[d] = 0; e_err[d] = 0; e_dv[d] = 0; e_data[d] = '0; e_bits[d] = 0;
        if (!rst_n) begin
            m_active[d] = 0; m_errd[d] = 0; m_pw[d] = 0; m_n[d] = 0;
            return;
        end
        if (in_soc) begin
            e_soc[d] = 1; m_active[d] = 1; m_errd[d] = 0; m_pw[d] = 0; m_n[d] = 0;
            return;
        end
        if (!m_active[d]) return;
        if (m_errd[d]) begin
            if (in_eoc) begin e_eoc[d] = 1; m_active[d] = 0; end
            return;
        end
        if (m_pw[d]) begin
            if (in_error || in_eoc) begin
                e_err[d] = 1; m_errd[d] = 1; m_pw[d] = 0; m_n[d] = 0;
                if (in_eoc) begin e_eoc[d] = 1; m_active[d] = 0; end
            end else if (in_data_valid) begin
                ones = int'(in_data);
                for (int i = 0; i < W[d]; i++) ones += int'(m_b[d][i]);
                if (ones % 2 == 1) begin e_dv[d] = 1; e_data[d] = pack(d, W[d]); end
                else begin e_err[d] = 1; m_errd[d] = 1; end
                m_pw[d] = 0; m_n[d] = 0;
            end
            return;
        end
        if (in_error) begin
            e_err[d] = 1; m_errd[d] = 1; m_n[d] = 0;
            if (in_eoc) begin e_eoc[d] = 1; m_active[d] = 0; end
            return;
        end
        if (in_data_valid) begin
            m_b[d][m_n[d]] = in_data;
            m_n[d]++;
            if (m_n[d] == W[d]) begin
                if (PAR) m_pw[d] = 1;
                else begin e_dv[d] = 1; e_data[d] = pack(d, W[d]); m_n[d] = 0; end
            end
        end
        if (in_eoc) begin
            e_eoc[d] = 1; m_active[d] = 0;
            if (m_pw[d]) begin e_err[d] = 1; m_pw[d] = 0; m_n[d] = 0; end
            else if (!e_dv[d]) begin e_bits[d] = m_n[d]; e_data[d] = pack(d, m_n[d]); end
            m_n[d] = 0;
        end
    endtask

    always @(posedge clk) for (int d = 0; d < 2; d++) model_step(d);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_dut(input int d, input logic s, input logic e, input logic r, input logic v,
                           input logic [31:0] data, input logic [31:0] bits);
        bit z;
        string p;
        z = !rst_n;
        p = $sformatf("w%0d", W[d]);
        chk({p, ".soc"},  32'(s),  z ? 32'd0 : 32'(e_soc[d]));
        chk({p, ".eoc"},  32'(e),  z ? 32'd0 : 32'(e_eoc[d]));
        chk({p, ".err"},  32'(r),  z ? 32'd0 : 32'(e_err[d]));
        chk({p, ".dv"},   32'(v),  z ? 32'd0 : 32'(e_dv[d]));
        chk({p, ".data"}, data,    z ? 32'd0 : e_data[d]);
        chk({p, ".bits"}, bits,    z ? 32'd0 : 32'(e_bits[d]));
        c_soc[d] += int'(s); c_eoc[d] += int'(e); c_err[d] += int'(r); c_dv[d] += int'(v);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk_dut(0, o8_soc, o8_eoc, o8_err, o8_dv, 32'(o8_data), 32'(o8_bits));
            chk_dut(1, o16_soc, o16_eoc, o16_err, o16_dv, 32'(o16_data), 32'(o16_bits));
        end
    end

    task automatic cyc(input logic s, input logic e, input logic r, input logic v, input logic b);
        in_soc = s; in_eoc = e; in_error = r; in_data_valid = v; in_data = b;
        @(posedge clk);
        #1;
        in_soc = 0; in_eoc = 0; in_error = 0; in_data_valid = 0; in_data = 0;
    endtask

    task automatic bit_in(input logic b);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic send_lsb(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) bit_in(v[i]);
    endtask

    task automatic send_msb(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int s_soc, s_eoc, s_err, s_dv, s_dv16;

    task automatic snap();
        s_soc = c_soc[0]; s_eoc = c_eoc[0]; s_err = c_err[0]; s_dv = c_dv[0]; s_dv16 = c_dv[1];
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        chk("reset.out_soc", 32'(o8_soc), 32'd0);
        chk("reset.out_data", 32'(o16_data), 32'd0);
        rst_n = 1'b1;
        idle(2);

`ifdef PARAM_DESERIALISER_PARITY_CHECK_EN
        cyc(1, 0, 0, 0, 0);
        send_lsb(32'h01, 8);
        chk("par.no_word_before_parity", 32'(o8_dv), 32'd0);
        bit_in(1'b0);
        chk("par.good.dv", 32'(o8_dv), 32'd1);
        chk("par.good.data", 32'(o8_data), 32'h01);
        cyc(0, 1, 0, 0, 0);
        chk("par.good.eoc", 32'(o8_eoc), 32'd1);
        idle(2);

        cyc(1, 0, 0, 0, 0);
        send_lsb(32'h01, 8);
        bit_in(1'b1);
        chk("par.bad.err", 32'(o8_err), 32'd1);
        chk("par.bad.dv", 32'(o8_dv), 32'd0);
        cyc(0, 1, 0, 0, 0);
        chk("par.bad.eoc", 32'(o8_eoc), 32'd1);
        idle(2);

        cyc(1, 0, 0, 0, 0);
        send_lsb(32'h01, 8);
        cyc(0, 1, 0, 0, 0);
        chk("par.eoc.err", 32'(o8_err), 32'd1);
        chk("par.eoc.eoc", 32'(o8_eoc), 32'd1);
        chk("par.eoc.bits", 32'(o8_bits), 32'd0);
        idle(2);
`else
        // 0xA5 LSB first, ending on a word boundary
        cyc(1, 0, 0, 0, 0);
        chk("a5.soc8", 32'(o8_soc), 32'd1);
        chk("a5.soc16", 32'(o16_soc), 32'd1);
        send_lsb(32'hA5, 8);
        chk("a5.dv", 32'(o8_dv), 32'd1);
        chk("a5.data", 32'(o8_data), 32'hA5);
        cyc(0, 1, 0, 0, 0);
        chk("a5.eoc", 32'(o8_eoc), 32'd1);
        chk("a5.bits", 32'(o8_bits), 32'd0);
        chk("a5.w16.bits", 32'(o16_bits), 32'd8);
        chk("a5.w16.data", 32'(o16_data), 32'hA500);
        idle(2);

        // 0x1234 MSB first then a 5-bit tail
        cyc(1, 0, 0, 0, 0);
        send_msb(32'h1234, 16);
        chk("1234.dv", 32'(o16_dv), 32'd1);
        chk("1234.data", 32'(o16_data), 32'h1234);
        chk("1234.w8.data", 32'(o8_data), 32'h2C);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);
        cyc(0, 1, 0, 0, 0);
        chk("tail.eoc", 32'(o16_eoc), 32'd1);
        chk("tail.bits", 32'(o16_bits), 32'd5);
        chk("tail.data", 32'(o16_data), 32'hB000);
        chk("tail.w8.bits", 32'(o8_bits), 32'd5);
        chk("tail.w8.data", 32'(o8_data), 32'h0D);
        idle(2);

        // Error mid-frame, error cycle also carries a bit that must be dropped
        snap();
        cyc(1, 0, 0, 0, 0);
        send_lsb(32'h4C3, 11);
        cyc(0, 0, 1, 1, 1);
        chk("err.pulse", 32'(o8_err), 32'd1);
        chk("err.dv", 32'(o8_dv), 32'd0);
        send_lsb(32'hF, 4);
        cyc(0, 1, 0, 0, 0);
        chk("err.eoc", 32'(o8_eoc), 32'd1);
        chk("err.eoc.bits", 32'(o8_bits), 32'd0);
        chk("err.eoc.data", 32'(o8_data), 32'd0);
        idle(2);
        chk("err.words", 32'(c_dv[0] - s_dv), 32'd1);
        chk("err.errors", 32'(c_err[0] - s_err), 32'd1);
        chk("err.w16.words", 32'(c_dv[1] - s_dv16), 32'd0);

        // Last bit of 0x3C coincides with end of frame
        cyc(1, 0, 0, 0, 0);
        send_lsb(32'h3C, 7);
        cyc(0, 1, 0, 1, 1'b0);
        chk("3c.dv", 32'(o8_dv), 32'd1);
        chk("3c.eoc", 32'(o8_eoc), 32'd1);
        chk("3c.data", 32'(o8_data), 32'h3C);
        chk("3c.bits", 32'(o8_bits), 32'd0);
        idle(2);

        // Restart after 3 bits
        snap();
        cyc(1, 0, 0, 0, 0);
        bit_in(1); bit_in(0); bit_in(1);
        cyc(1, 0, 0, 0, 0);
        send_lsb(32'hFF, 8);
        chk("restart.data", 32'(o8_data), 32'hFF);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        chk("restart.socs", 32'(c_soc[0] - s_soc), 32'd2);
        chk("restart.words", 32'(c_dv[0] - s_dv), 32'd1);
        chk("restart.eocs", 32'(c_eoc[0] - s_eoc), 32'd1);

        // Everything but in_soc is ignored while idle
        snap();
        cyc(0, 1, 1, 1, 1);
        send_lsb(32'hFF, 8);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        chk("idle.eocs", 32'(c_eoc[0] - s_eoc), 32'd0);
        chk("idle.errors", 32'(c_err[0] - s_err), 32'd0);
        chk("idle.words", 32'(c_dv[0] - s_dv), 32'd0);

        // Error together with end of frame
        cyc(1, 0, 0, 0, 0);
        bit_in(1); bit_in(1);
        cyc(0, 1, 1, 0, 0);
        chk("erreoc.err", 32'(o8_err), 32'd1);
        chk("erreoc.eoc", 32'(o8_eoc), 32'd1);
        idle(2);

        // Only one error pulse per frame
        snap();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        send_lsb(32'hFF, 8);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        chk("one_err.errors", 32'(c_err[0] - s_err), 32'd1);
        chk("one_err.words", 32'(c_dv[0] - s_dv), 32'd0);

        // Reset mid-frame aborts silently
        cyc(1, 0, 0, 0, 0);
        bit_in(1); bit_in(0); bit_in(1);
        rst_n = 1'b0;
        idle(2);
        chk("midrst.soc", 32'(o8_soc), 32'd0);
        rst_n = 1'b1;
        snap();
        send_lsb(32'hFF, 8);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        chk("midrst.words", 32'(c_dv[0] - s_dv), 32'd0);
        chk("midrst.eocs", 32'(c_eoc[0] - s_eoc), 32'd0);
`endif

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
